uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int OVS_DEFAULT        = 16;
  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, head shown combinationally,
// push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             ovr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovr     = push && full && !do_pop;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop line sync, free-running oversample divider,
// frame FSM and receive FIFO. Define UART_RX_PARITY_EN to expect an
// even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int OVS        = OVS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_d,
  input  logic [15:0] cfg_div,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        fifo_full,
  output logic        busy,
  output logic        par_err,
  output logic        frm_err,
  output logic        ovr_err
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [15:0]   div_cnt_q, div_cnt_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          push_q, push_d;
  logic          rx_s, tick, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
`endif

  assign rx_s = sync_q[1];
  assign busy = (state_q != IDLE);

  // Two-stage synchroniser for the asynchronous serial line.
  always_comb begin
    sync_d = {sync_q[0], rx_d};
  end

  // Tick divider; the divisor is only re-latched between frames.
  always_comb begin
    div_lat_d = div_lat_q;
    if (state_q == IDLE) div_lat_d = (cfg_div == 16'd0) ? 16'd1 : cfg_div;
    tick      = (div_cnt_q >= div_lat_q - 16'd1);
    div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
  end

  // Frame FSM: next state, sampling, error pulses and push request.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    push_d     = 1'b0;
    frm_err    = 1'b0;
    par_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        // After a framing error the line must be seen high before re-arming.
        if (rx_s) armed_d = 1'b1;
        if (!rx_s && armed_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: if (tick) begin
        if (tick_cnt_q == HALF_LAST) begin
          tick_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      DATA: if (tick) begin
        if (tick_cnt_q == FULL_LAST) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        if (tick_cnt_q == FULL_LAST) begin
          tick_cnt_d = '0;
          par_bad_d  = (rx_s != ^shift_q);
          state_d    = STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`endif
      STOP: if (tick) begin
        if (tick_cnt_q == FULL_LAST) begin
          tick_cnt_d = '0;
          state_d    = IDLE;
          if (!rx_s) begin
            frm_err = 1'b1;
            armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_err = 1'b1;
`endif
          end else begin
            push_d  = 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      div_cnt_q  <= '0;
      div_lat_q  <= 16'd1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b1;
      push_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      push_q     <= push_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .push_data(shift_q),
    .pop      (rd_en),
    .head     (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovr      (ovr_err)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus randomized frames checked
// against a byte-queue reference model. Follows UART_RX_PARITY_EN.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int OVS   = 16;
  localparam int DIV   = 2;
  localparam int BIT   = OVS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_d = 1'b1;
  logic [15:0] cfg_div = 16'(DIV);
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid, fifo_full, busy, par_err, frm_err, ovr_err;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .rx_d(rx_d), .cfg_div(cfg_div), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_full(fifo_full), .busy(busy),
    .par_err(par_err), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int par_cnt = 0, frm_cnt = 0, ovr_cnt = 0, busy_cyc = 0;
  logic [7:0] exp_q [$];

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  // Pulse and activity counters observed away from the active edge.
  always @(negedge clk) begin
    if (par_err) par_cnt  <= par_cnt + 1;
    if (frm_err) frm_cnt  <= frm_cnt + 1;
    if (ovr_err) ovr_cnt  <= ovr_cnt + 1;
    if (busy)    busy_cyc <= busy_cyc + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic v);
    rx_d = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Serial frame; optionally pops exactly in the cycle the byte is pushed.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                            input bit pop_at_push, output bit popped);
    bit was_busy;
    popped = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR_ON) send_bit((^b) ^ bad_par);
    rx_d = stop_v;
    was_busy = 1'b1;
    for (int i = 0; i < BIT; i++) begin
      @(negedge clk);
      rd_en = 1'b0;
      if (pop_at_push && !popped && was_busy && !busy) begin
        chk("head_at_push", rd_data, exp_q[0]);
        rd_en  = 1'b1;
        popped = 1'b1;
      end
      was_busy = busy;
    end
    rd_en = 1'b0;
  endtask

  // Send one frame and compare every observable against the queue model.
  task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                           input bit pop_at_push);
    int p0, f0, o0;
    bit popped, eff_bad, exp_ovr;
    p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt;
    eff_bad = PAR_ON && bad_par;
    exp_ovr = 1'b0;
    send_frame(b, bad_par, stop_v, pop_at_push, popped);
    repeat (4) @(negedge clk);
    if (pop_at_push) chk("pop_window", popped, 1'b1);
    if (popped) void'(exp_q.pop_front());
    if (stop_v && !eff_bad) begin
      if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
      else exp_q.push_back(b);
    end
    $display("frame 0x%02h bad_par=%0d stop=%0d pop_at_push=%0d queued=%0d",
             b, eff_bad, stop_v, popped, exp_q.size());
    chk("frm_err_count", frm_cnt - f0, (!stop_v) ? 1 : 0);
    chk("par_err_count", par_cnt - p0, (stop_v && eff_bad) ? 1 : 0);
    chk("ovr_err_count", ovr_cnt - o0, exp_ovr ? 1 : 0);
    chk("busy_after", busy, 1'b0);
    chk("rd_valid", rd_valid, (exp_q.size() != 0) ? 1 : 0);
    chk("fifo_full", fifo_full, (exp_q.size() == DEPTH) ? 1 : 0);
    if (exp_q.size() != 0) chk("rd_data_head", rd_data, exp_q[0]);
    if (!stop_v) begin
      int b0;
      b0 = busy_cyc;
      repeat (BIT * $urandom_range(1, 3)) @(negedge clk);
      chk("no_restart_while_low", busy_cyc - b0, 0);
      rx_d = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      $display("pop expect 0x%02h got 0x%02h", exp_q[0], rd_data);
      chk("rd_valid_pop", rd_valid, 1'b1);
      chk("rd_data_pop", rd_data, exp_q[0]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk("empty_after_drain", rd_valid, 1'b0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    chk("pop_empty_ignored", rd_valid, 1'b0);
    chk("full_after_drain", fifo_full, 1'b0);
  endtask

  initial begin
    int b0, p0, f0, o0;
    bit dummy;
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_par_err", par_err, 1'b0);
    chk("rst_frm_err", frm_err, 1'b0);
    chk("rst_ovr_err", ovr_err, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame, bad parity frame, bad stop frame.
    run_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    drain();
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    drain();
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    drain();

    // False start: line low for four ticks only.
    b0 = busy_cyc; p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt;
    rx_d = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx_d = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    $display("false start busy_cycles=%0d", busy_cyc - b0);
    chk("false_start_busy", (busy_cyc != b0) ? 1 : 0, 1);
    chk("false_start_idle", busy, 1'b0);
    chk("false_start_errs", (par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0), 0);
    chk("false_start_nopush", rd_valid, 1'b0);

    // Overflow on the fifth byte, then in-order pops.
    for (int i = 1; i <= 5; i++) run_frame(8'(i), 1'b0, 1'b1, 1'b0);
    drain();

    // Push and pop coinciding while full.
    for (int i = 0; i < DEPTH; i++) run_frame(8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
    run_frame(8'h99, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset in the middle of a frame; FIFO contents are lost too.
    run_frame(8'h55, 1'b0, 1'b1, 1'b0);
    p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(dummy ^ 1'b1 ^ !(8'h77 >> i & 1));
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_valid", rd_valid, 1'b0);
    rx_d = 1'b1;
    rst  = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("midrst_errs", (par_cnt - p0) + (frm_cnt - f0) + (ovr_cnt - o0), 0);
    run_frame(8'h12, 1'b0, 1'b1, 1'b0);
    drain();

    // Randomized frames with random error injection and random draining.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      int kind;
      bit pap;
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 5);
      pap  = (kind >= 2) && (exp_q.size() == DEPTH) && ($urandom_range(0, 1) == 1);
      run_frame(b, kind == 0, kind != 1, pap);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
